// File: rtl/rtc_timekeeper.sv
// rtc_timekeeper
// ----------------------------------------------------------------------------
// Time-of-day counter (hh:mm:ss) in a single clock domain. Time advances on a
// 1 Hz enable pulse while in run mode. In set mode the field selected by the
// one-hot set_pos can be stepped up or down with wrap, and no carry or borrow
// passes into neighbouring fields. An optional hh:mm alarm comparator raises
// alarm_hit for one cycle when a run-mode tick lands exactly on hh:mm:00.
// day_pulse marks the 23:59:59 -> 00:00:00 rollover.
//
// Ports
//   clk         in   1  system clock, rising edge
//   reset       in   1  asynchronous, active-low reset
//   tick_1hz    in   1  single-cycle 1 Hz enable
//   mode        in   1  0 = run, 1 = set
//   set_pos     in   3  one-hot field select: 100 hour, 010 min, 001 sec
//   inc, dec    in   1  set-mode step pulses for the selected field
//   fmt12       in   1  1 = 12-hour display, 0 = 24-hour display
//   al_we       in   1  alarm write strobe (range-checked)
//   al_hour_in  in   5  alarm hour, 0-23
//   al_min_in   in   6  alarm minute, 0-59
//   alarm_en    in   1  alarm enable
//   sec_out     out  6  seconds (registered)
//   min_out     out  6  minutes (registered)
//   hour_out    out  5  display hour, decoded from hour24 per fmt12
//   hour24_out  out  5  internal hour 0-23 (registered)
//   pm_out      out  1  hour24 >= 12
//   day_pulse   out  1  one-cycle day rollover event (registered)
//   alarm_hit   out  1  one-cycle alarm event (registered)
// ----------------------------------------------------------------------------
module rtc_timekeeper #(
    parameter int unsigned RESET_HOUR = 0,
    parameter int unsigned RESET_MIN  = 0,
    parameter int unsigned RESET_SEC  = 0,
    parameter int unsigned ALARM_EN   = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       tick_1hz,
    input  logic       mode,
    input  logic [2:0] set_pos,
    input  logic       inc,
    input  logic       dec,
    input  logic       fmt12,
    input  logic       al_we,
    input  logic [4:0] al_hour_in,
    input  logic [5:0] al_min_in,
    input  logic       alarm_en,
    output logic [5:0] sec_out,
    output logic [5:0] min_out,
    output logic [4:0] hour_out,
    output logic [4:0] hour24_out,
    output logic       pm_out,
    output logic       day_pulse,
    output logic       alarm_hit
);

    localparam logic [5:0] RST_SEC_C  = 6'(RESET_SEC);
    localparam logic [5:0] RST_MIN_C  = 6'(RESET_MIN);
    localparam logic [4:0] RST_HOUR_C = 5'(RESET_HOUR);

    // Wrapping +/-1 step for a 0..max_v field of 6 bits (seconds, minutes).
    function automatic logic [5:0] step6(input logic [5:0] v,
                                         input logic [5:0] max_v,
                                         input logic       up);
        logic [5:0] r;
        if (up) begin
            r = (v >= max_v) ? 6'd0 : v + 6'd1;
        end else begin
            r = (v == 6'd0) ? max_v : v - 6'd1;
        end
        return r;
    endfunction

    // Wrapping +/-1 step for the 0..23 hour field.
    function automatic logic [4:0] step_hour(input logic [4:0] v,
                                             input logic       up);
        logic [4:0] r;
        if (up) begin
            r = (v >= 5'd23) ? 5'd0 : v + 5'd1;
        end else begin
            r = (v == 5'd0) ? 5'd23 : v - 5'd1;
        end
        return r;
    endfunction

    logic [5:0] sec_r;
    logic [5:0] min_r;
    logic [4:0] hour_r;
    logic       day_pulse_r;
    logic       alarm_hit_r;
    logic [4:0] al_hour_r;
    logic [5:0] al_min_r;
    logic       alarm_active_s;

    logic [5:0] sec_nx_s;
    logic [5:0] min_nx_s;
    logic [4:0] hour_nx_s;
    logic       day_nx_s;
    logic       hit_nx_s;
    logic       run_tick_s;
    logic       set_step_s;
    logic [4:0] hour_disp_s;

    // Tick counts only in run mode; a set step needs exactly one of inc/dec.
    assign run_tick_s = ~mode & tick_1hz;
    assign set_step_s = mode & (inc ^ dec);

    // Next-state for the time fields and the two event pulses.
    always_comb begin
        sec_nx_s  = sec_r;
        min_nx_s  = min_r;
        hour_nx_s = hour_r;
        day_nx_s  = 1'b0;
        hit_nx_s  = 1'b0;
        if (run_tick_s) begin
            // Full carry chain resolves on the same edge.
            if (sec_r == 6'd59) begin
                sec_nx_s = 6'd0;
                if (min_r == 6'd59) begin
                    min_nx_s = 6'd0;
                    if (hour_r == 5'd23) begin
                        hour_nx_s = 5'd0;
                        day_nx_s  = 1'b1;
                    end else begin
                        hour_nx_s = hour_r + 5'd1;
                    end
                end else begin
                    min_nx_s = min_r + 6'd1;
                end
                // Alarm can only match when seconds land on 00; compares
                // against the alarm registers before any same-cycle write.
                hit_nx_s = alarm_active_s &&
                           (min_nx_s == al_min_r) && (hour_nx_s == al_hour_r);
            end else begin
                sec_nx_s = sec_r + 6'd1;
            end
        end else if (set_step_s) begin
            case (set_pos)
                3'b100:  hour_nx_s = step_hour(hour_r, inc);
                3'b010:  min_nx_s  = step6(min_r, 6'd59, inc);
                3'b001:  sec_nx_s  = step6(sec_r, 6'd59, inc);
                default: begin
                    sec_nx_s = sec_r;
                end
            endcase
        end else begin
            sec_nx_s = sec_r;
        end
    end

    // Time and event-pulse registers.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sec_r       <= RST_SEC_C;
            min_r       <= RST_MIN_C;
            hour_r      <= RST_HOUR_C;
            day_pulse_r <= 1'b0;
            alarm_hit_r <= 1'b0;
        end else begin
            sec_r       <= sec_nx_s;
            min_r       <= min_nx_s;
            hour_r      <= hour_nx_s;
            day_pulse_r <= day_nx_s;
            alarm_hit_r <= hit_nx_s;
        end
    end

    generate
        if (ALARM_EN != 0) begin : g_alarm
            logic al_ok_s;

            // A write is accepted only when both fields are in range.
            assign al_ok_s = al_we && (al_hour_in <= 5'd23) && (al_min_in <= 6'd59);
            assign alarm_active_s = alarm_en;

            // Alarm hour/minute registers.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    al_hour_r <= 5'd0;
                    al_min_r  <= 6'd0;
                end else if (al_ok_s) begin
                    al_hour_r <= al_hour_in;
                    al_min_r  <= al_min_in;
                end else begin
                    al_hour_r <= al_hour_r;
                    al_min_r  <= al_min_r;
                end
            end
        end else begin : g_no_alarm
            assign al_hour_r      = 5'd0;
            assign al_min_r       = 6'd0;
            assign alarm_active_s = 1'b0;
        end
    endgenerate

    // 12-hour decode: 0 shows as 12, afternoon hours drop by 12.
    always_comb begin
        hour_disp_s = hour_r;
        if (!fmt12) begin
            hour_disp_s = hour_r;
        end else if (hour_r == 5'd0) begin
            hour_disp_s = 5'd12;
        end else if (hour_r > 5'd12) begin
            hour_disp_s = hour_r - 5'd12;
        end else begin
            hour_disp_s = hour_r;
        end
    end

    assign sec_out    = sec_r;
    assign min_out    = min_r;
    assign hour24_out = hour_r;
    assign hour_out   = hour_disp_s;
    assign pm_out     = (hour_r >= 5'd12);
    assign day_pulse  = day_pulse_r;
    assign alarm_hit  = alarm_hit_r;

endmodule
